// File: rtl/verif_pkg.sv
// Shared definitions for the verificador_mux response checker.
// - State encoding of the checker FSM (IDLE / ARM / RUN / DONE).
// - Bit positions of the per-output mismatch word.
// - bit_differs(): X/Z-aware comparison of one DUT response bit against its golden value.
package verif_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StArm  = S_ARM,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

  localparam int unsigned MM_MUX  = 0;
  localparam int unsigned MM_NOT  = 1;
  localparam int unsigned MM_AND  = 2;
  localparam int unsigned MM_OR   = 3;
  localparam int unsigned MM_FLOP = 4;
  localparam int unsigned MM_W    = 5;

  // A bit only passes when both sides are a clean, equal 0 or 1, so X/Z on either the response
  // or on a stimulus feeding the golden value is reported as a mismatch. In hardware this
  // reduces to a plain XOR.
  function automatic logic bit_differs(logic act, logic exp);
    return !(((act === 1'b0) && (exp === 1'b0)) || ((act === 1'b1) && (exp === 1'b1)));
  endfunction

endpackage

// File: rtl/verificador_mux_if.sv
// Bus between the stimulus/DUT side of the bench and the verificador_mux checker.
// - master: bench side; drives start, sample_valid, the stimulus vector and the DUT responses,
//   reads back the checker results.
// - slave : checker side; the mirror image.
// Signals: start, sample_valid, dataInA, dataInB, dataIn0, dataIn1, selector (stimulus);
//          dataOut, outNot, outAnd, outOr, out_flop (DUT responses);
//          mismatch, vector_count, error_count, first_err_idx, first_err_mask, busy, done, pass
//          (checker results).
interface verificador_mux_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic                        start;
  logic                        sample_valid;
  logic                        dataInA;
  logic                        dataInB;
  logic                        dataIn0;
  logic                        dataIn1;
  logic                        selector;
  logic                        dataOut;
  logic                        outNot;
  logic                        outAnd;
  logic                        outOr;
  logic                        out_flop;
  logic [verif_pkg::MM_W-1:0]  mismatch;
  logic [CNT_W-1:0]            vector_count;
  logic [CNT_W-1:0]            error_count;
  logic [CNT_W-1:0]            first_err_idx;
  logic [verif_pkg::MM_W-1:0]  first_err_mask;
  logic                        busy;
  logic                        done;
  logic                        pass;

  modport master (
    output start, sample_valid, dataInA, dataInB, dataIn0, dataIn1, selector,
    output dataOut, outNot, outAnd, outOr, out_flop,
    input  mismatch, vector_count, error_count, first_err_idx, first_err_mask, busy, done, pass
  );

  modport slave (
    input  start, sample_valid, dataInA, dataInB, dataIn0, dataIn1, selector,
    input  dataOut, outNot, outAnd, outOr, out_flop,
    output mismatch, vector_count, error_count, first_err_idx, first_err_mask, busy, done, pass
  );

endinterface

// File: rtl/golden_mux_gates.sv
// Golden reference for the mux/gates DUT.
// Ports:
//   clk, reset_L          - clock and synchronous active-low reset (clears prev_mux)
//   data_in_a_i/b_i       - gate operands
//   data_in_0_i/1_i       - mux data inputs
//   selector_i            - mux select
//   exp_mux_o ... exp_or_o - combinational expected responses
//   exp_flop_o            - mux result of the previous cycle
module golden_mux_gates (
  input  logic clk,
  input  logic reset_L,
  input  logic data_in_a_i,
  input  logic data_in_b_i,
  input  logic data_in_0_i,
  input  logic data_in_1_i,
  input  logic selector_i,
  output logic exp_mux_o,
  output logic exp_not_o,
  output logic exp_and_o,
  output logic exp_or_o,
  output logic exp_flop_o
);

  logic prev_mux_q;

  always_comb begin
    exp_mux_o = selector_i ? data_in_1_i : data_in_0_i;
    exp_not_o = ~data_in_a_i;
    exp_and_o = data_in_a_i & data_in_b_i;
    exp_or_o  = data_in_a_i | data_in_b_i;
  end

  // Registered every cycle, valid or not, just like the DUT's own flop.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      prev_mux_q <= 1'b0;
    end else begin
      prev_mux_q <= exp_mux_o;
    end
  end

  assign exp_flop_o = prev_mux_q;

endmodule

// File: rtl/verificador_mux.sv
// Response checker for the mux/gates DUT.
// Samples the stimulus vector and the DUT responses each cycle, compares them with the golden
// model, and counts vectors and failing vectors over a run of NUM_VECTORS valid vectors.
// Ports:
//   clk     - rising-edge clock
//   reset_L - synchronous active-low reset, overrides everything
//   bus     - slave side of verificador_mux_if (start, sample_valid, stimulus, DUT responses in;
//             mismatch, counters, first-error capture, busy/done/pass out)
// The interface instance must use the same CNT_W as this module.
module verificador_mux
  import verif_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 8,
  parameter int unsigned CNT_W       = 8
) (
  input logic              clk,
  input logic              reset_L,
  verificador_mux_if.slave bus
);

  // The vector counter must never wrap within a run.
  if (NUM_VECTORS == 0 || CNT_W == 0 || CNT_W > 31 ||
      NUM_VECTORS >= (32'd1 << CNT_W)) begin : g_param_check
    $error("verificador_mux: need 0 < NUM_VECTORS < 2**CNT_W and 0 < CNT_W < 32");
  end

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(NUM_VECTORS);

  logic exp_mux, exp_not, exp_and, exp_or, exp_flop;

  golden_mux_gates u_golden (
    .clk         (clk),
    .reset_L     (reset_L),
    .data_in_a_i (bus.dataInA),
    .data_in_b_i (bus.dataInB),
    .data_in_0_i (bus.dataIn0),
    .data_in_1_i (bus.dataIn1),
    .selector_i  (bus.selector),
    .exp_mux_o   (exp_mux),
    .exp_not_o   (exp_not),
    .exp_and_o   (exp_and),
    .exp_or_o    (exp_or),
    .exp_flop_o  (exp_flop)
  );

  state_e            state_q, state_d;
  logic              prev_valid_q, prev_valid_d;
  logic [MM_W-1:0]   mm_q, mm_d;
  logic [CNT_W-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  fidx_q, fidx_d;
  logic [MM_W-1:0]   fmask_q, fmask_d;
  logic              busy_q, done_q, pass_q;
  logic [MM_W-1:0]   mm_chk;

  // Per-output comparison of the current vector. The flop check needs a valid vector in the
  // previous cycle of the same run; otherwise the golden flop value is meaningless.
  always_comb begin
    mm_chk          = '0;
    mm_chk[MM_MUX]  = bit_differs(bus.dataOut, exp_mux);
    mm_chk[MM_NOT]  = bit_differs(bus.outNot,  exp_not);
    mm_chk[MM_AND]  = bit_differs(bus.outAnd,  exp_and);
    mm_chk[MM_OR]   = bit_differs(bus.outOr,   exp_or);
    mm_chk[MM_FLOP] = (state_q == StRun) && prev_valid_q && bit_differs(bus.out_flop, exp_flop);
  end

  always_comb begin
    state_d      = state_q;
    prev_valid_d = 1'b0;
    mm_d         = mm_q;
    vec_d        = vec_q;
    err_d        = err_q;
    fidx_d       = fidx_q;
    fmask_d      = fmask_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StArm;
          vec_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fmask_d = '0;
        end
      end

      StArm, StRun: begin
        prev_valid_d = bus.sample_valid;
        if (bus.sample_valid) begin
          mm_d  = mm_chk;
          vec_d = vec_q + 1'b1;
          if (|mm_chk) begin
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            // Only the first failing vector of the run is captured.
            if (err_q == '0) begin
              fidx_d  = vec_q;
              fmask_d = mm_chk;
            end
          end
          state_d = (vec_d == LastCount) ? StDone : StRun;
        end else begin
          mm_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q      <= StIdle;
      prev_valid_q <= 1'b0;
      mm_q         <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      fidx_q       <= '0;
      fmask_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      mm_q         <= mm_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      fidx_q       <= fidx_d;
      fmask_q      <= fmask_d;
      busy_q       <= (state_d == StArm) || (state_d == StRun);
      done_q       <= (state_d == StDone);
      pass_q       <= (state_d == StDone) && (err_d == '0);
    end
  end

  assign bus.mismatch       = mm_q;
  assign bus.vector_count   = vec_q;
  assign bus.error_count    = err_q;
  assign bus.first_err_idx  = fidx_q;
  assign bus.first_err_mask = fmask_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;

endmodule

// File: tb/tb_verificador_mux.sv
// Bench for verificador_mux: emulates a (possibly faulty) mux/gates DUT, keeps a run-level
// model of what the checker must report, compares every cycle, and adds literal checks.
module tb_verificador_mux;
  import verif_pkg::*;

  localparam int NV = 8;

  localparam int F_NONE     = 0;  // correct DUT
  localparam int F_AND      = 1;  // outAnd stuck at 0
  localparam int F_TIED     = 2;  // out_flop follows dataOut with no delay
  localparam int F_FLOP_BAD = 3;  // out_flop inverted

  localparam int M_IDLE = 0, M_FIRST = 1, M_RUN = 2, M_DONE = 3;

  logic clk;
  logic reset_L;

  verificador_mux_if #(.CNT_W(8)) bus ();

  verificador_mux #(.NUM_VECTORS(NV), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- run-level model of the checker ----------------
  int         m_mode = M_IDLE;
  bit         m_prev_ok = 1'b0;
  logic       m_prev_mux = 1'b0;
  logic [4:0] e_mm = '0;
  int         e_vec = 0, e_err = 0, e_fidx = 0;
  logic [4:0] e_fmask = '0;

  always @(posedge clk) begin
    logic       g_mux;
    logic [4:0] bits;
    g_mux = bus.selector ? bus.dataIn1 : bus.dataIn0;
    if (!reset_L) begin
      m_mode = M_IDLE; m_prev_ok = 1'b0; m_prev_mux = 1'b0;
      e_mm = '0; e_vec = 0; e_err = 0; e_fidx = 0; e_fmask = '0;
    end else begin
      if (m_mode == M_IDLE || m_mode == M_DONE) begin
        m_prev_ok = 1'b0;
        if (bus.start) begin
          m_mode = M_FIRST; e_vec = 0; e_err = 0; e_fidx = 0; e_fmask = '0;
        end
      end else if (!bus.sample_valid) begin
        e_mm = '0;
        m_prev_ok = 1'b0;
      end else begin
        bits[MM_MUX]  = (bus.dataOut != g_mux);
        bits[MM_NOT]  = (bus.outNot != !bus.dataInA);
        bits[MM_AND]  = (bus.outAnd != (bus.dataInA && bus.dataInB));
        bits[MM_OR]   = (bus.outOr != (bus.dataInA || bus.dataInB));
        bits[MM_FLOP] = m_prev_ok && (bus.out_flop != m_prev_mux);
        e_mm = bits;
        if (bits != 0) begin
          if (e_err == 0) begin
            e_fidx = e_vec;
            e_fmask = bits;
          end
          if (e_err < 255) e_err++;
        end
        e_vec++;
        m_prev_ok = 1'b1;
        m_mode = (e_vec == NV) ? M_DONE : M_RUN;
      end
      m_prev_mux = g_mux;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cmp_en) begin
        chk("cyc_mismatch", bus.mismatch, e_mm);
        chk("cyc_vector_count", bus.vector_count, e_vec);
        chk("cyc_error_count", bus.error_count, e_err);
        chk("cyc_first_err_idx", bus.first_err_idx, e_fidx);
        chk("cyc_first_err_mask", bus.first_err_mask, e_fmask);
        chk("cyc_busy", bus.busy, (m_mode == M_FIRST || m_mode == M_RUN));
        chk("cyc_done", bus.done, (m_mode == M_DONE));
        chk("cyc_pass", bus.pass, (m_mode == M_DONE && e_err == 0));
      end
    end
  end

  // ---------------- DUT emulation and stimulus ----------------
  logic [4:0] std_v [NV];  // {A, B, D0, D1, sel}
  logic [4:0] cur_v = '0;
  logic       last_mux = 1'b0;

  task automatic drive(input logic [4:0] v, input bit valid, input int fault, input bit st,
                       input bit rst_n);
    logic a, b, d0, d1, s, mux;
    @(negedge clk);
    {a, b, d0, d1, s} = v;
    mux = s ? d1 : d0;
    reset_L          = rst_n;
    bus.start        = st;
    bus.sample_valid = valid;
    {bus.dataInA, bus.dataInB, bus.dataIn0, bus.dataIn1, bus.selector} = v;
    bus.dataOut  = mux;
    bus.outNot   = ~a;
    bus.outAnd   = (fault == F_AND) ? 1'b0 : (a & b);
    bus.outOr    = a | b;
    bus.out_flop = (fault == F_TIED) ? mux : ((fault == F_FLOP_BAD) ? ~last_mux : last_mux);
    last_mux = rst_n ? mux : 1'b0;
    cur_v = v;
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic start_run();
    drive(cur_v, 1'b0, F_NONE, 1'b1, 1'b1);
  endtask

  task automatic chk_end(input string tag, input int vec, input int err, input bit ps);
    chk({tag, "_vector_count"}, bus.vector_count, vec);
    chk({tag, "_error_count"}, bus.error_count, err);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_pass"}, bus.pass, ps);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    std_v[0] = 5'b0000_0; std_v[1] = 5'b0101_0; std_v[2] = 5'b1010_0; std_v[3] = 5'b1111_0;
    std_v[4] = 5'b0000_1; std_v[5] = 5'b0101_1; std_v[6] = 5'b1010_1; std_v[7] = 5'b1111_1;
    reset_L = 1'b0;
    bus.start = 0; bus.sample_valid = 0;
    bus.dataInA = 0; bus.dataInB = 0; bus.dataIn0 = 0; bus.dataIn1 = 0; bus.selector = 0;
    bus.dataOut = 0; bus.outNot = 1; bus.outAnd = 0; bus.outOr = 0; bus.out_flop = 0;

    // Reset state
    settle();
    chk("rst_mismatch", bus.mismatch, 0);
    chk("rst_vector_count", bus.vector_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    cmp_en = 1'b1;

    // start together with reset: reset wins
    drive(cur_v, 1'b0, F_NONE, 1'b1, 1'b0);
    settle();
    chk("rst_start_busy", bus.busy, 0);

    // Run 1: clean run; a start pulse mid-run is ignored
    start_run();
    for (int i = 0; i < NV; i++) drive(std_v[i], 1'b1, F_NONE, (i == 2), 1'b1);
    settle();
    chk_end("clean", 8, 0, 1'b1);
    // Valid (and faulty) vectors in DONE are ignored
    drive(std_v[3], 1'b1, F_AND, 1'b0, 1'b1);
    drive(std_v[3], 1'b1, F_AND, 1'b0, 1'b1);
    settle();
    chk("done_ignore_vec", bus.vector_count, 8);
    chk("done_ignore_mm", bus.mismatch, 0);

    // Run 2: outAnd stuck at 0 on vector 3
    start_run();
    for (int i = 0; i < NV; i++) begin
      drive(std_v[i], 1'b1, (i == 3) ? F_AND : F_NONE, 1'b0, 1'b1);
      if (i == 3) begin
        settle();
        chk("and_mismatch", bus.mismatch, 5'b00100);
      end
    end
    settle();
    chk_end("and", 8, 1, 1'b0);
    chk("and_first_idx", bus.first_err_idx, 3);
    chk("and_first_mask", bus.first_err_mask, 5'b00100);

    // Run 3: start from DONE after a failing run, then out_flop tied to dataOut
    start_run();
    settle();
    chk("restart_error_count", bus.error_count, 0);
    chk("restart_vector_count", bus.vector_count, 0);
    chk("restart_first_mask", bus.first_err_mask, 0);
    chk("restart_busy", bus.busy, 1);
    for (int i = 0; i < NV; i++) begin
      drive({2'b00, i[0], 1'b0, 1'b0}, 1'b1, F_TIED, 1'b0, 1'b1);
      if (i == 0) begin
        settle();
        chk("tied_v0_flop", bus.mismatch[MM_FLOP], 0);
      end else if (i == 1) begin
        settle();
        chk("tied_v1_mismatch", bus.mismatch, 5'b10000);
      end
    end
    settle();
    chk_end("tied", 8, 7, 1'b0);
    chk("tied_first_idx", bus.first_err_idx, 1);
    chk("tied_first_mask", bus.first_err_mask, 5'b10000);

    // Run 4: two-cycle gap after vector 4, wrong out_flop on vector 5
    start_run();
    for (int i = 0; i < 5; i++) drive(std_v[i], 1'b1, F_NONE, 1'b0, 1'b1);
    drive(cur_v, 1'b0, F_NONE, 1'b0, 1'b1);
    drive(cur_v, 1'b0, F_NONE, 1'b0, 1'b1);
    settle();
    chk("gap_vector_count", bus.vector_count, 5);
    chk("gap_mismatch", bus.mismatch, 0);
    chk("gap_busy", bus.busy, 1);
    drive(std_v[5], 1'b1, F_FLOP_BAD, 1'b0, 1'b1);
    settle();
    chk("gap_v5_flop", bus.mismatch[MM_FLOP], 0);
    chk("gap_v5_vector_count", bus.vector_count, 6);
    for (int i = 6; i < NV; i++) drive(std_v[i], 1'b1, F_NONE, 1'b0, 1'b1);
    settle();
    chk_end("gap", 8, 0, 1'b1);

    // Run 5: reset in RUN at vector_count = 5, then a clean run
    start_run();
    for (int i = 0; i < 5; i++) drive(std_v[i], 1'b1, (i == 1) ? F_AND : F_NONE, 1'b0, 1'b1);
    settle();
    chk("midrst_pre_vector_count", bus.vector_count, 5);
    drive(std_v[5], 1'b1, F_AND, 1'b1, 1'b0);
    settle();
    chk("midrst_mismatch", bus.mismatch, 0);
    chk("midrst_vector_count", bus.vector_count, 0);
    chk("midrst_error_count", bus.error_count, 0);
    chk("midrst_first_idx", bus.first_err_idx, 0);
    chk("midrst_first_mask", bus.first_err_mask, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_pass", bus.pass, 0);
    drive(cur_v, 1'b0, F_NONE, 1'b0, 1'b1);
    start_run();
    for (int i = 0; i < NV; i++) drive(std_v[i], 1'b1, F_NONE, 1'b0, 1'b1);
    settle();
    chk_end("postrst", 8, 0, 1'b1);

    drive(cur_v, 1'b0, F_NONE, 1'b0, 1'b1);
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
